// File: rtl/pipe_pkg.sv
// Shared pipeline payload widths and the MEM/WB bundle field layout.
package pipe_pkg;

  localparam int unsigned IFID_W  = 64;   // pc+4, instruction
  localparam int unsigned IDEX_W  = 147;  // ctrl 9, pc, rs, rt, imm, rt/rd
  localparam int unsigned EXMEM_W = 76;   // ctrl 5, zero, overflow, alu, rt, Rw
  localparam int unsigned MEMWB_W = 72;   // {WB[1:0], overflow, Dm, result, Rw}

  localparam int unsigned MEMWB_RW_LSB     = 0;
  localparam int unsigned MEMWB_RESULT_LSB = 5;
  localparam int unsigned MEMWB_DM_LSB     = 37;
  localparam int unsigned MEMWB_OVF_BIT    = 69;
  localparam int unsigned MEMWB_WB_LSB     = 70;

  function automatic logic [MEMWB_W-1:0] memwb_pack(input logic [1:0]  wb,
                                                    input logic        ovf,
                                                    input logic [31:0] dm,
                                                    input logic [31:0] result,
                                                    input logic [4:0]  rw);
    return {wb, ovf, dm, result, rw};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush, optional
// two-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MEMWB_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (SKID == 0) begin : g_single
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready = out_ready | ~valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
        data_q  <= in_data;
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
  end else begin : g_skid
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q;
    logic              valid_q;
    logic              ready_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              xfer_in;
    logic              xfer_out;

    assign xfer_in  = in_valid & ready_q;
    assign xfer_out = valid_q & out_ready;

    // ready_q is precomputed as "next state is not StFull" so in_ready is a flop.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StEmpty;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
        main_q  <= '0;
        skid_q  <= '0;
      end else if (flush) begin
        state_q <= StEmpty;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (xfer_in) begin
              main_q  <= in_data;
              valid_q <= 1'b1;
              state_q <= StOne;
            end
          end
          StOne: begin
            if (xfer_in && xfer_out) begin
              main_q <= in_data;
            end else if (xfer_in) begin
              skid_q  <= in_data;
              ready_q <= 1'b0;
              state_q <= StFull;
            end else if (xfer_out) begin
              valid_q <= 1'b0;
              state_q <= StEmpty;
            end
          end
          StFull: begin
            if (xfer_out) begin
              main_q  <= skid_q;
              skid_q  <= '0;
              ready_q <= 1'b1;
              state_q <= StOne;
            end
          end
          default: begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: a skid instance (CNT_W=16) and a single-register instance (CNT_W=4)
// compared every cycle against queue-based reference models.
module tb_pipe_stage_reg;

  localparam int unsigned W = 72;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [W-1:0] a_in_data = '0;
  logic         a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;
  logic [15:0]  a_stall;

  logic         b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [W-1:0] b_in_data = '0;
  logic         b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;
  logic [3:0]   b_stall;

  pipe_stage_reg #(.DATA_W(W), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .stall_cnt(b_stall)
  );

  // Reference: a stage is a FIFO of capacity 2 (skid) or 1 (single register).
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] da = '0, db = '0;
  int           ca = 0, cb = 0;
  bit           chk_en = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_models();
    chk("a_out_valid", W'(a_out_valid), W'(qa.size() > 0));
    chk("a_in_ready",  W'(a_in_ready),  W'(qa.size() < 2));
    chk("a_out_data",  a_out_data, da);
    chk("a_stall_cnt", W'(a_stall), W'(ca));
    chk("b_out_valid", W'(b_out_valid), W'(qb.size() > 0));
    chk("b_in_ready",  W'(b_in_ready),  W'((qb.size() == 0) || b_out_ready));
    chk("b_out_data",  b_out_data, db);
    chk("b_stall_cnt", W'(b_stall), W'(cb));
  endtask

  task automatic step_models();
    bit va, ra, vb, rb;
    if (rst) begin
      qa.delete(); qb.delete();
      da = '0; db = '0; ca = 0; cb = 0;
      return;
    end
    va = qa.size() > 0;
    ra = qa.size() < 2;
    if (va && !a_out_ready && ca < 65535) ca++;
    if (a_flush) qa.delete();
    else begin
      if (va && a_out_ready) void'(qa.pop_front());
      if (a_in_valid && ra) qa.push_back(a_in_data);
    end
    if (qa.size() > 0) da = qa[0];

    vb = qb.size() > 0;
    rb = (qb.size() == 0) || b_out_ready;
    if (vb && !b_out_ready && cb < 15) cb++;
    if (b_flush) qb.delete();
    else begin
      if (vb && b_out_ready) void'(qb.pop_front());
      if (b_in_valid && rb) qb.push_back(b_in_data);
    end
    if (qb.size() > 0) db = qb[0];
  endtask

  // Check pre-edge outputs on the falling edge, advance the model, return just after the edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) check_models();
    step_models();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [95:0] r;
    int stall_snap;

    // Reset with a valid all-ones transfer presented on both instances.
    rst = 1;
    a_in_valid = 1; a_in_data = {W{1'b1}}; a_out_ready = 0;
    b_in_valid = 1; b_in_data = {W{1'b1}}; b_out_ready = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0; a_in_valid = 0; b_in_valid = 0; b_out_ready = 1;
    #1;
    chk("rst_a_valid", W'(a_out_valid), '0);
    chk("rst_a_data",  a_out_data, '0);
    chk("rst_a_ready", W'(a_in_ready), W'(1));
    chk("rst_a_stall", W'(a_stall), '0);
    chk("rst_b_valid", W'(b_out_valid), '0);
    chk("rst_b_data",  b_out_data, '0);
    chk("rst_b_ready", W'(b_in_ready), W'(1));

    // Streaming through the skid instance.
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = W'(i);
      tick();
      chk("stream_data", a_out_data, W'(i));
    end
    a_in_valid = 0;
    tick();

    // Backpressure: A, B then C held for several stalled cycles.
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = W'('h11); tick();
    a_in_data = W'('h22); tick();
    a_in_data = W'('h33); tick(); tick(); tick();
    chk("bp_stall4", W'(a_stall), W'(4));
    chk("bp_ready0", W'(a_in_ready), '0);
    chk("bp_mainA",  a_out_data, W'('h11));
    a_out_ready = 1;
    tick(); tick();
    a_in_valid = 0;
    tick(); tick();
    chk("bp_drained", W'(a_out_valid), '0);

    // Flush while full, with a same-cycle transfer that must be discarded.
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = W'('h11); tick();
    a_in_data = W'('h22); tick();
    stall_snap = ca;
    a_flush = 1; a_in_data = W'('h44); tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl_valid", W'(a_out_valid), '0);
    chk("fl_ready", W'(a_in_ready), W'(1));
    chk("fl_stall", W'(a_stall), W'(6));
    chk("fl_stall_kept", W'(a_stall), W'(stall_snap + 1));
    a_out_ready = 1;
    tick(); tick();

    // Single-register stall: in_ready drops combinationally, then load-while-leave.
    b_in_valid = 1; b_in_data = W'('h55); b_out_ready = 0; tick();
    b_in_data = W'('h66); #1;
    chk("s0_ready_low", W'(b_in_ready), '0);
    chk("s0_hold",      b_out_data, W'('h55));
    tick();
    b_out_ready = 1; #1;
    chk("s0_ready_high", W'(b_in_ready), W'(1));
    tick();
    chk("s0_new", b_out_data, W'('h66));
    chk("s0_new_valid", W'(b_out_valid), W'(1));

    // Saturate the 4-bit stall counter.
    b_in_valid = 0; b_out_ready = 0;
    repeat (20) tick();
    chk("sat_15", W'(b_stall), W'(15));

    // Randomised traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      a_in_valid = 1'($urandom_range(0, 3) != 0);
      a_in_data = r[W-1:0];
      a_out_ready = 1'($urandom_range(0, 2) != 0);
      a_flush = 1'($urandom_range(0, 19) == 0);
      r = {$urandom(), $urandom(), $urandom()};
      b_in_valid = 1'($urandom_range(0, 3) != 0);
      b_in_data = r[W-1:0];
      b_out_ready = 1'($urandom_range(0, 2) != 0);
      b_flush = 1'($urandom_range(0, 19) == 0);
      rst = (i == 200);
      tick();
    end
    rst = 0; a_flush = 0; b_flush = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
